// File: rtl/uart_pkg.sv
// uart_pkg: shared state/word-length types, oversample constant and stop-length helper for the UART TX path
// Contents:
//   BAUD_OVERSAMPLE  brc ticks per bit at the default build
//   tx_state_t       serializer FSM states
//   wlen_t           word length code (5..8 data bits)
//   stop_ticks()     stop period length in brc ticks for a given stb/wlen
package uart_pkg;
   localparam int BAUD_OVERSAMPLE = 16;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
   typedef enum logic [1:0] {WLEN_5, WLEN_6, WLEN_7, WLEN_8} wlen_t;
   // 2 stop bits shrink to 1.5 for 5-bit words
   function automatic logic [7:0] stop_ticks(input logic stb, input wlen_t wlen);
      return !stb ? 8'(BAUD_OVERSAMPLE)
           : (wlen == WLEN_5) ? 8'(BAUD_OVERSAMPLE * 3 / 2)
           : 8'(2 * BAUD_OVERSAMPLE);
   endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts brc ticks within one bit period and flags the half-bit and full-bit boundaries
// Ports:
//   i_clk       clock (FIFO read clock)
//   i_rst_n     asynchronous active-low reset
//   i_brc       baud clock enable, one pulse per tick
//   i_clear     restart the bit period (tick count back to 0)
//   o_bit_end   this tick completes a full bit
//   o_half_end  this tick completes the first half of a bit
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = BAUD_OVERSAMPLE
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_brc,
   input  logic i_clear,
   output logic o_bit_end,
   output logic o_half_end
);
   localparam int CW = $clog2(OVERSAMPLE);
   logic [CW-1:0] r_cnt;
   assign o_bit_end  = i_brc && (r_cnt == CW'(OVERSAMPLE - 1));
   assign o_half_end = i_brc && (r_cnt == CW'(OVERSAMPLE / 2 - 1));
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n)
         r_cnt <= '0;
      else if (i_clear)
         r_cnt <= '0;
      else if (i_brc)
         r_cnt <= o_bit_end ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from the TX FIFO and shifts out start/data/parity/stop bits on o_sd
// Optional feature: define UART_TX_BREAK_EN to add i_brk, which forces o_sd low while the FSM keeps running.
// Ports:
//   i_clk        clock, same as FIFO read clock
//   i_rst_n      asynchronous active-low reset
//   i_brc        baud clock enable, OVERSAMPLE pulses per bit
//   i_fifo_empty TX FIFO empty flag
//   i_fifo_q     TX FIFO head word, valid while not empty
//   o_fifo_rd    1-clk pop strobe to the FIFO
//   i_wlen       word length: 00=5 .. 11=8 data bits
//   i_stb        0=1 stop bit, 1=2 stop bits (1.5 for 5-bit words)
//   i_pen        parity enable
//   i_eps        even parity select
//   i_stick      stick parity (parity bit = ~eps)
//   i_brk        break request (UART_TX_BREAK_EN only)
//   o_sd         serial data, idle high
//   o_busy       high from pop through the end of the last stop bit
//   o_tx_done    1-clk pulse on the last tick of the stop period
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = BAUD_OVERSAMPLE,
   parameter int DATA_W     = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_brc,
   input  logic              i_fifo_empty,
   input  logic [DATA_W-1:0] i_fifo_q,
   output logic              o_fifo_rd,
   input  logic [1:0]        i_wlen,
   input  logic              i_stb,
   input  logic              i_pen,
   input  logic              i_eps,
   input  logic              i_stick,
`ifdef UART_TX_BREAK_EN
   input  logic              i_brk,
`endif
   output logic              o_sd,
   output logic              o_busy,
   output logic              o_tx_done
);
   tx_state_t  r_state;
   logic [7:0] r_shift;
   logic       r_par;
   logic [2:0] r_bit_cnt;
   wlen_t      r_wlen;
   logic       r_stb, r_pen, r_eps, r_stick;
   logic       r_sd, r_busy;
   logic       w_bit_end, w_half_end, w_stop_end, w_pop;
   logic       w_par_next, w_par_bit;
   logic [2:0] w_last_data, w_stop_halves;

   uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_brc      (i_brc),
      .i_clear    (w_pop),
      .o_bit_end  (w_bit_end),
      .o_half_end (w_half_end)
   );

   assign w_last_data   = {1'b0, r_wlen} + 3'd4;
   // stop period measured in half bits (2, 3 or 4); r_bit_cnt counts completed halves in STOP
   assign w_stop_halves = 3'(stop_ticks(r_stb, r_wlen) / 8'(BAUD_OVERSAMPLE / 2));
   assign w_stop_end    = (r_state == STOP) && (w_bit_end || w_half_end) && (r_bit_cnt == w_stop_halves - 3'd1);
   // reset gating keeps a pop from leaking out while reset is held
   assign w_pop         = i_rst_n && !i_fifo_empty && ((r_state == IDLE) || w_stop_end);
   assign w_par_next    = r_par ^ r_shift[0];
   assign w_par_bit     = r_stick ? ~r_eps : (w_par_next ^ ~r_eps);

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_par     <= 1'b0;
         r_bit_cnt <= '0;
         r_wlen    <= WLEN_5;
         r_stb     <= 1'b0;
         r_pen     <= 1'b0;
         r_eps     <= 1'b0;
         r_stick   <= 1'b0;
         r_sd      <= 1'b1;
         r_busy    <= 1'b0;
      end else if (w_pop) begin
         r_state   <= START;
         r_sd      <= 1'b0;
         r_busy    <= 1'b1;
         r_shift   <= i_fifo_q[7:0];
         r_par     <= 1'b0;
         r_bit_cnt <= '0;
         r_wlen    <= wlen_t'(i_wlen);
         r_stb     <= i_stb;
         r_pen     <= i_pen;
         r_eps     <= i_eps;
         r_stick   <= i_stick;
      end else begin
         case (r_state)
            START:
               if (w_bit_end) begin
                  r_state <= DATA;
                  r_sd    <= r_shift[0];
               end
            DATA:
               if (w_bit_end) begin
                  r_par   <= w_par_next;
                  r_shift <= r_shift >> 1;
                  if (r_bit_cnt == w_last_data) begin
                     r_bit_cnt <= '0;
                     r_state   <= r_pen ? PARITY : STOP;
                     r_sd      <= r_pen ? w_par_bit : 1'b1;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     r_sd      <= r_shift[1];
                  end
               end
            PARITY:
               if (w_bit_end) begin
                  r_state <= STOP;
                  r_sd    <= 1'b1;
               end
            STOP:
               if (w_stop_end) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (w_bit_end || w_half_end)
                  r_bit_cnt <= r_bit_cnt + 3'd1;
            default: ;
         endcase
      end

`ifdef UART_TX_BREAK_EN
   logic r_brk;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n)
         r_brk <= 1'b0;
      else
         r_brk <= i_brk;
   assign o_sd = r_sd & ~r_brk;
`else
   assign o_sd = r_sd;
`endif
   assign o_fifo_rd = w_pop;
   assign o_busy    = r_busy;
   assign o_tx_done = w_stop_end;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench for the UART TX serializer (FIFO model, frame monitor, reset/break cases)
module tb_uart_tx_serializer;
   localparam int OS = 16;
   typedef struct {
      logic [7:0] data;
      logic [1:0] wlen;
      logic       stb, pen, eps, stick;
   } frame_t;

   logic       clk = 1'b0, rst_n = 1'b0, brc = 1'b0;
   logic       stb = 1'b0, pen = 1'b0, eps = 1'b0, stick = 1'b0, brk = 1'b0, brk_q = 1'b0;
   logic [1:0] wlen = 2'b11;
   logic       fifo_empty, fifo_rd, sd, busy, tx_done;
   logic [7:0] fifo_q;
   logic [7:0] mem [32];
   int         wr_ptr = 0, rd_ptr = 0;
   frame_t     sb[$];
   int         n_checks = 0, n_fail = 0, pops = 0, busy_clks = 0, brc_div = 1, brc_cnt = 0;

   assign fifo_empty = (rd_ptr == wr_ptr);
   assign fifo_q     = mem[rd_ptr % 32];

   always #5 clk = ~clk;

   uart_tx_serializer dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_brc        (brc),
      .i_fifo_empty (fifo_empty),
      .i_fifo_q     (fifo_q),
      .o_fifo_rd    (fifo_rd),
      .i_wlen       (wlen),
      .i_stb        (stb),
      .i_pen        (pen),
      .i_eps        (eps),
      .i_stick      (stick),
`ifdef UART_TX_BREAK_EN
      .i_brk        (brk),
`endif
      .o_sd         (sd),
      .o_busy       (busy),
      .o_tx_done    (tx_done)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      brc = (brc_cnt == 0);
      brc_cnt = (brc_cnt + 1) % brc_div;
   end

   always @(posedge clk) begin
      brk_q <= brk;
      busy_clks <= busy_clks + (busy ? 1 : 0);
      if (fifo_rd) begin
         check("rd_while_empty", fifo_empty, 0);
         rd_ptr <= rd_ptr + 1;
         pops <= pops + 1;
      end
   end

   task automatic set_cfg(input logic [1:0] w, input logic s, input logic p, input logic e, input logic k);
      wlen = w; stb = s; pen = p; eps = e; stick = k;
   endtask

   task automatic push(input logic [7:0] d);
      frame_t f;
      mem[wr_ptr % 32] = d;
      wr_ptr++;
      f.data = d; f.wlen = wlen; f.stb = stb; f.pen = pen; f.eps = eps; f.stick = stick;
      sb.push_back(f);
   endtask

   task automatic run_frame();
      frame_t f;
      logic   segv[12];
      int     segt[12];
      int     nseg;
      logic   par;
      if (sb.size() == 0) begin
         check("sb_underflow", 1, 0);
         @(negedge clk);
         return;
      end
      f = sb.pop_front();
      segv[0] = 1'b0; segt[0] = OS; nseg = 1; par = 1'b0;
      for (int i = 0; i < int'(f.wlen) + 5; i++) begin
         segv[nseg] = f.data[i]; segt[nseg] = OS; par ^= f.data[i]; nseg++;
      end
      if (f.pen) begin
         segv[nseg] = f.stick ? ~f.eps : (par ^ ~f.eps); segt[nseg] = OS; nseg++;
      end
      segv[nseg] = 1'b1;
      segt[nseg] = !f.stb ? OS : (f.wlen == 2'b00 ? OS * 3 / 2 : 2 * OS);
      nseg++;
      for (int s = 0; s < nseg; s++) begin
         int ticks = 0, clks = 0, bad = 0;
         logic exp_done;
         while (ticks < segt[s]) begin
            @(negedge clk);
            #1;
            if (!rst_n) return;
            if (sd !== (brk_q ? 1'b0 : segv[s])) bad++;
            if (busy !== 1'b1) bad++;
            exp_done = (s == nseg - 1) && brc && (ticks == segt[s] - 1);
            if (tx_done !== exp_done) bad++;
            if (exp_done) check("pop_on_done", fifo_rd, !fifo_empty);
            @(posedge clk);
            clks++;
            if (brc) ticks++;
         end
         if (s > 0 && clks != segt[s] * brc_div) bad++;
         check($sformatf("frame_%02h_seg%0d", f.data, s), bad, 0);
      end
   endtask

   always begin
      @(posedge clk);
      while (rst_n && fifo_rd) run_frame();
   end

   task automatic wait_idle();
      int n = 0;
      repeat (3) @(negedge clk);
      while ((busy || !fifo_empty) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", int'(n < 20000), 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int b, p, zeros;
      repeat (3) @(negedge clk);
      #1;
      check("rst_sd", sd, 1);
      check("rst_busy", busy, 0);
      check("rst_fifo_rd", fifo_rd, 0);
      check("rst_tx_done", tx_done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      set_cfg(2'b11, 0, 0, 0, 0); b = busy_clks; p = pops; push(8'h55); wait_idle();
      check("8n1_busy", busy_clks - b, 160);
      check("8n1_pops", pops - p, 1);

      set_cfg(2'b10, 0, 1, 1, 0); b = busy_clks; push(8'h41); wait_idle();
      check("7e1_busy", busy_clks - b, 160);

      set_cfg(2'b00, 1, 0, 0, 0); b = busy_clks; push(8'h1F); wait_idle();
      check("5n15_busy", busy_clks - b, 120);

      set_cfg(2'b00, 1, 1, 0, 1); b = busy_clks; push(8'h1F); wait_idle();
      check("5stick_busy", busy_clks - b, 136);

      set_cfg(2'b11, 0, 0, 0, 0); b = busy_clks; p = pops; push(8'hA5); push(8'h3C); wait_idle();
      check("b2b_busy", busy_clks - b, 320);
      check("b2b_pops", pops - p, 2);

      set_cfg(2'b11, 1, 1, 0, 0); b = busy_clks; push(8'h96);
      repeat (5) @(negedge clk);
      set_cfg(2'b00, 0, 0, 1, 1);
      wait_idle();
      check("cfg_hold_busy", busy_clks - b, 192);

      repeat (6) begin
         set_cfg(2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'($urandom_range(1)), 1'($urandom_range(1)));
         push(8'($urandom_range(255)));
         wait_idle();
      end

      brc_div = 4;
      set_cfg(2'b11, 0, 0, 0, 0); p = pops; push(8'h5A);
`ifdef UART_TX_BREAK_EN
      repeat (100) @(negedge clk);
      brk = 1'b1;
      repeat (50) @(negedge clk);
      brk = 1'b0;
`endif
      wait_idle();
      check("div4_pops", pops - p, 1);
      brc_div = 1;
      repeat (4) @(negedge clk);

      set_cfg(2'b11, 0, 0, 0, 0); push(8'hF0);
      repeat (OS + 2 * OS + 8) @(negedge clk);
      #1;
      check("pre_rst_sd", sd, 0);
      check("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_sd", sd, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_rd", fifo_rd, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      p = pops; zeros = 0;
      repeat (100) begin
         @(negedge clk);
         #1;
         if (!sd) zeros++;
      end
      check("post_rst_pops", pops - p, 0);
      check("post_rst_sd_low", zeros, 0);

      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
